// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, FSM encoding
// and the data-memory window check.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } lsu_state_e;

  // Compared in 33 bits so a window ending at the top of the address space cannot wrap.
  function automatic logic lsu_in_range(input logic [31:0] addr,
                                        input logic [31:0] base,
                                        input int unsigned words);
    logic [32:0] lo;
    logic [32:0] hi;
    lo = {1'b0, base};
    hi = lo + (33'(words) << 2);
    return ({1'b0, addr} >= lo) && ({1'b0, addr} < hi);
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: picks the byte/halfword lane out of a memory word and
// sign- or zero-extends it according to funct3.
import lsu_pkg::*;

module lsu_load_align (
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o   = '0;
    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'd0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'd0, half_sel};
      F3_W:    data_o = rdata_i;
      default: data_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_dmem_master.sv
// Load/store initiator for a 1-cycle-latency synchronous data memory, one transaction in flight.
// Define MISALIGN_TRAP_EN to report misaligned H/W accesses as errors instead of force-aligning them.
import lsu_pkg::*;

module lsu_dmem_master #(
  parameter logic [31:0] DMEM_BASE  = 32'h0000_0000,
  parameter int unsigned DMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [4:0]  req_rd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic [4:0]  rsp_rd,
  output logic        rsp_err,
  output logic        dmem_re,
  output logic [31:0] dmem_raddr,
  output logic        dmem_we,
  output logic [31:0] dmem_waddr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_wstrb,
  input  logic [31:0] dmem_rdata
);

  lsu_state_e  state_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic        rsp_err_q;
  logic [31:0] rsp_data_q;
  logic [4:0]  rsp_rd_q;
  logic        dmem_re_q;
  logic        dmem_we_q;
  logic [31:0] dmem_raddr_q;
  logic [31:0] dmem_waddr_q;
  logic [31:0] dmem_wdata_q;
  logic [3:0]  dmem_wstrb_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;

  logic        f3_ok;
  logic        acc_err;
  logic [31:0] eff_addr;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [31:0] load_data;

  // Request decode, evaluated against the live request while IDLE.
  always_comb begin
    eff_addr = req_addr;
    st_wdata = req_wdata;
    st_wstrb = 4'b1111;
    case (req_funct3[1:0])
      2'b00: begin
        st_wdata = {4{req_wdata[7:0]}};
        st_wstrb = 4'b0001 << req_addr[1:0];
      end
      2'b01: begin
        eff_addr[0] = 1'b0;
        st_wdata    = {2{req_wdata[15:0]}};
        st_wstrb    = 4'b0011 << {req_addr[1], 1'b0};
      end
      default: eff_addr[1:0] = 2'b00;
    endcase
    if (req_we) f3_ok = (req_funct3 inside {F3_B, F3_H, F3_W});
    else        f3_ok = (req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    acc_err = !f3_ok || !lsu_in_range(req_addr, DMEM_BASE, DMEM_WORDS);
`ifdef MISALIGN_TRAP_EN
    if ((req_funct3[1:0] == 2'b01 && req_addr[0]) ||
        (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00))
      acc_err = 1'b1;
`endif
  end

  lsu_load_align u_align (
    .rdata_i  (dmem_rdata),
    .lane_i   (lane_q),
    .funct3_i (funct3_q),
    .data_o   (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
      rsp_rd_q     <= '0;
      dmem_re_q    <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_raddr_q <= '0;
      dmem_waddr_q <= '0;
      dmem_wdata_q <= '0;
      dmem_wstrb_q <= '0;
      funct3_q     <= '0;
      lane_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            req_ready_q <= 1'b0;
            rsp_rd_q    <= req_rd;
            funct3_q    <= req_funct3;
            lane_q      <= eff_addr[1:0];
            if (acc_err) begin
              state_q     <= ST_RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rsp_data_q  <= '0;
            end else begin
              state_q <= ST_ACCESS;
              if (req_we) begin
                dmem_we_q    <= 1'b1;
                dmem_waddr_q <= eff_addr;
                dmem_wdata_q <= st_wdata;
                dmem_wstrb_q <= st_wstrb;
              end else begin
                dmem_re_q    <= 1'b1;
                dmem_raddr_q <= eff_addr;
              end
            end
          end
        end
        ST_ACCESS: begin
          dmem_re_q    <= 1'b0;
          dmem_we_q    <= 1'b0;
          dmem_wstrb_q <= '0;
          if (dmem_we_q) begin
            state_q     <= ST_RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
          end else begin
            state_q <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          state_q     <= ST_RESP;
          rsp_valid_q <= 1'b1;
          rsp_err_q   <= 1'b0;
          rsp_data_q  <= load_data;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = req_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_rd     = rsp_rd_q;
  assign dmem_re    = dmem_re_q;
  assign dmem_we    = dmem_we_q;
  assign dmem_raddr = dmem_raddr_q;
  assign dmem_waddr = dmem_waddr_q;
  assign dmem_wdata = dmem_wdata_q;
  assign dmem_wstrb = dmem_wstrb_q;

endmodule
